// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + data ports), the arbiter and the unified memory.
interface mem_arbiter_if;
   logic        i_req, i_cancel, i_valid, i_stall;
   logic [15:0] i_addr, i_data;
   logic        d_req, d_wr, d_valid, d_stall;
   logic [15:0] d_addr, d_wdata, d_rdata;
   logic        mem_en, mem_wr, busy;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   modport slave (
      input  i_req, i_addr, i_cancel, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output i_data, i_valid, i_stall, d_rdata, d_valid, d_stall,
      output mem_en, mem_wr, mem_addr, mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, i_cancel, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  i_data, i_valid, i_stall, d_rdata, d_valid, d_stall,
      input  mem_en, mem_wr, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter for a single-ported memory with a fixed
// per-access hold time; registered read data with one-cycle valid pulses.
module mem_arbiter #(
   parameter int LATENCY = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          drop, drop_nx;
   logic          grant_i, grant_d, done, fetch_ok;
   logic          mem_en, mem_wr, busy;
   logic [15:0]   addr_q, wdata_q, i_data_q, d_rdata_q;
   logic          wr_q, i_valid_q, d_valid_q;
   logic          i_elig, d_elig;

   // A port is not re-granted in the cycle its own result is being delivered.
   assign i_elig   = bus.i_req & ~i_valid_q;
   assign d_elig   = bus.d_req & ~d_valid_q;
   assign fetch_ok = ~(drop | bus.i_cancel);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         drop  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         drop  <= drop_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      drop_nx  = drop;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      done     = 1'b0;
      mem_en   = 1'b0;
      mem_wr   = 1'b0;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            drop_nx = 1'b0;
            if (d_elig) begin
               grant_d  = 1'b1;
               state_nx = BUSY_D;
               cnt_nx   = CW'(LATENCY - 1);
            end else if (i_elig) begin
               grant_i  = 1'b1;
               state_nx = BUSY_I;
               cnt_nx   = CW'(LATENCY - 1);
               drop_nx  = bus.i_cancel;
            end
         end
         BUSY_I, BUSY_D: begin
            mem_en = 1'b1;
            busy   = 1'b1;
            mem_wr = (state == BUSY_D) & wr_q;
            if (state == BUSY_I && bus.i_cancel) drop_nx = 1'b1;
            // Memory cannot abort: a cancelled fetch still runs its full hold time.
            if (cnt == '0) begin
               done     = 1'b1;
               state_nx = IDLE;
               drop_nx  = 1'b0;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         i_data_q  <= '0;
         d_rdata_q <= '0;
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
      end else begin
         i_valid_q <= done & (state == BUSY_I) & fetch_ok;
         d_valid_q <= done & (state == BUSY_D);
         if (grant_d) begin
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            wr_q    <= bus.d_wr;
         end else if (grant_i) begin
            addr_q <= bus.i_addr;
         end
         if (done && state == BUSY_I && fetch_ok) i_data_q  <= bus.mem_rdata;
         if (done && state == BUSY_D && !wr_q)    d_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.mem_en    = mem_en;
   assign bus.mem_wr    = mem_wr;
   assign bus.busy      = busy;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.i_data    = i_data_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.i_valid   = i_valid_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.i_stall   = bus.i_req & ~i_valid_q;
   assign bus.d_stall   = bus.d_req & ~d_valid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed test-plan scenarios followed by protocol-legal random traffic, each cycle
// compared against a timestamp-based transaction model of the arbiter.
module tb_mem_arbiter;
   localparam int L = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus();
   mem_arbiter #(.LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [15:0] ram  [256];
   logic [15:0] mram [256];
   assign bus.mem_rdata = ram[bus.mem_addr[11:4]];

   int checks = 0;
   int errors = 0;

   // Reference model: an access is described by its grant cycle; it occupies
   // the memory for cycles start+1 .. start+L and delivers in cycle start+L+1.
   longint      cyc = 0;
   longint      a_start = -100;
   int          a_kind = 0;        // 0 none, 1 fetch, 2 data
   logic [15:0] a_addr, a_wdata;
   logic        a_wr, a_drop;
   logic [15:0] e_i_data, e_d_rdata, e_maddr, e_mwdata;
   logic        e_i_valid, e_d_valid;
   logic        i_hold = 1'b0, d_hold = 1'b0;

   function automatic logic in_busy(input longint c);
      return (a_kind != 0) && (c > a_start) && (c <= a_start + L);
   endfunction

   task automatic model_reset();
      a_kind = 0; a_drop = 1'b0; a_wr = 1'b0;
      a_addr = '0; a_wdata = '0;
      e_i_data = '0; e_d_rdata = '0; e_maddr = '0; e_mwdata = '0;
      e_i_valid = 1'b0; e_d_valid = 1'b0;
   endtask

   task automatic model_edge();
      logic nv_i, nv_d;
      nv_i = 1'b0; nv_d = 1'b0;
      if (in_busy(cyc)) begin
         if (a_kind == 1 && bus.i_cancel) a_drop = 1'b1;
         if (cyc == a_start + L) begin
            if (a_kind == 1 && !a_drop) begin
               e_i_data = mram[a_addr[11:4]];
               nv_i = 1'b1;
            end
            if (a_kind == 2) begin
               if (a_wr) mram[a_addr[11:4]] = a_wdata;
               else      e_d_rdata = mram[a_addr[11:4]];
               nv_d = 1'b1;
            end
            a_kind = 0;
         end
      end else if (bus.d_req && !e_d_valid) begin
         a_kind = 2; a_start = cyc; a_addr = bus.d_addr; a_wr = bus.d_wr;
         a_wdata = bus.d_wdata; e_maddr = bus.d_addr; e_mwdata = bus.d_wdata;
      end else if (bus.i_req && !e_i_valid) begin
         a_kind = 1; a_start = cyc; a_addr = bus.i_addr; a_drop = bus.i_cancel;
         e_maddr = bus.i_addr;
      end
      e_i_valid = nv_i;
      e_d_valid = nv_d;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %h want %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic eb;
      eb = in_busy(cyc);
      chk("mem_en",    {15'd0, bus.mem_en},  {15'd0, eb});
      chk("busy",      {15'd0, bus.busy},    {15'd0, eb});
      chk("mem_wr",    {15'd0, bus.mem_wr},  {15'd0, eb && a_kind == 2 && a_wr});
      chk("mem_addr",  bus.mem_addr,  e_maddr);
      chk("mem_wdata", bus.mem_wdata, e_mwdata);
      chk("i_valid",   {15'd0, bus.i_valid}, {15'd0, e_i_valid});
      chk("d_valid",   {15'd0, bus.d_valid}, {15'd0, e_d_valid});
      chk("i_data",    bus.i_data,  e_i_data);
      chk("d_rdata",   bus.d_rdata, e_d_rdata);
      chk("i_stall",   {15'd0, bus.i_stall}, {15'd0, bus.i_req && !e_i_valid});
      chk("d_stall",   {15'd0, bus.d_stall}, {15'd0, bus.d_req && !e_d_valid});
   endtask

   // Entered 1 time unit after a rising edge with this cycle's inputs applied.
   task automatic cycle();
      @(negedge clk);
      check_outputs();
      i_hold = bus.i_req && !e_i_valid && !bus.i_cancel;
      d_hold = bus.d_req && !e_d_valid;
      if (bus.mem_en && bus.mem_wr) ram[bus.mem_addr[11:4]] = bus.mem_wdata;
      if (!rst) model_edge();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   function automatic logic [15:0] rand_addr();
      return {8'h00, 1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
   endfunction

   task automatic rand_drive();
      if (!i_hold) begin
         bus.i_req  = ($urandom_range(0, 1) == 1);
         bus.i_addr = rand_addr();
      end
      bus.i_cancel = ($urandom_range(0, 9) == 0);
      if (!d_hold) begin
         bus.d_req   = ($urandom_range(0, 2) == 0);
         bus.d_wr    = ($urandom_range(0, 1) == 1);
         bus.d_addr  = rand_addr();
         bus.d_wdata = 16'($urandom);
      end
   endtask

   task automatic preload(input logic [15:0] addr, input logic [15:0] val);
      ram[addr[11:4]]  = val;
      mram[addr[11:4]] = val;
   endtask

   initial begin
      rst = 1'b1;
      bus.i_req = 1'b0; bus.i_addr = '0; bus.i_cancel = 1'b0;
      bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         ram[i]  = 16'($urandom);
         mram[i] = ram[i];
      end
      model_reset();
      preload(16'h0010, 16'hA5A5);
      preload(16'h0020, 16'h1357);
      preload(16'h0200, 16'h00FF);
      preload(16'h0050, 16'hBEEF);
      repeat (2) cycle();
      rst = 1'b0;
      cycle();

      // Single fetch
      bus.i_req = 1'b1; bus.i_addr = 16'h0010;
      cycle();
      chk("t1_mem_en_c1", {15'd0, bus.mem_en}, 16'd1);
      repeat (4) cycle();
      chk("t1_i_valid_c5", {15'd0, bus.i_valid}, 16'd1);
      chk("t1_i_data", bus.i_data, 16'hA5A5);
      cycle();
      bus.i_req = 1'b0;
      cycle();

      // Simultaneous fetch and load: data wins
      bus.i_req = 1'b1; bus.i_addr = 16'h0020;
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0200; bus.d_wdata = 16'h0000;
      repeat (5) cycle();
      chk("t2_d_valid_c5", {15'd0, bus.d_valid}, 16'd1);
      chk("t2_d_rdata", bus.d_rdata, 16'h00FF);
      cycle();
      bus.d_req = 1'b0;
      chk("t2_fetch_addr_c6", bus.mem_addr, 16'h0020);
      repeat (4) cycle();
      chk("t2_i_valid_c10", {15'd0, bus.i_valid}, 16'd1);
      chk("t2_i_data", bus.i_data, 16'h1357);
      cycle();
      bus.i_req = 1'b0;

      // Store
      bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0300; bus.d_wdata = 16'h1234;
      cycle();
      chk("t3_mem_wr_c1", {15'd0, bus.mem_wr}, 16'd1);
      chk("t3_mem_wdata", bus.mem_wdata, 16'h1234);
      repeat (4) cycle();
      chk("t3_d_valid_c5", {15'd0, bus.d_valid}, 16'd1);
      chk("t3_d_rdata_kept", bus.d_rdata, 16'h00FF);
      cycle();
      bus.d_req = 1'b0; bus.d_wr = 1'b0;

      // Cancelled fetch, then a load queued behind it
      bus.i_req = 1'b1; bus.i_addr = 16'h0030;
      repeat (2) cycle();
      bus.i_cancel = 1'b1;
      cycle();
      bus.i_cancel = 1'b0; bus.i_req = 1'b0;
      bus.d_req = 1'b1; bus.d_addr = 16'h0040;
      repeat (2) cycle();
      chk("t4_no_i_valid", {15'd0, bus.i_valid}, 16'd0);
      chk("t4_i_data_kept", bus.i_data, 16'h1357);
      cycle();
      chk("t4_d_addr_c6", bus.mem_addr, 16'h0040);
      repeat (4) cycle();
      chk("t4_d_valid_c10", {15'd0, bus.d_valid}, 16'd1);
      cycle();
      bus.d_req = 1'b0;

      // Reset in the middle of a load
      bus.d_req = 1'b1; bus.d_addr = 16'h0050;
      repeat (2) cycle();
      #1 rst = 1'b1;
      #1;
      chk("t5_mem_en_rst", {15'd0, bus.mem_en}, 16'd0);
      chk("t5_busy_rst", {15'd0, bus.busy}, 16'd0);
      model_reset();
      cycle();
      rst = 1'b0;
      repeat (5) cycle();
      chk("t5_d_valid_c5", {15'd0, bus.d_valid}, 16'd1);
      chk("t5_d_rdata", bus.d_rdata, 16'hBEEF);
      cycle();
      bus.d_req = 1'b0;

      // Valid-cycle exclusion: held fetch request loses to a new load
      bus.i_req = 1'b1; bus.i_addr = 16'h0060;
      repeat (5) cycle();
      bus.d_req = 1'b1; bus.d_addr = 16'h0070;
      cycle();
      bus.i_addr = 16'h0080;
      chk("t6_d_addr_c6", bus.mem_addr, 16'h0070);
      repeat (4) cycle();
      chk("t6_d_valid_c10", {15'd0, bus.d_valid}, 16'd1);
      cycle();
      bus.d_req = 1'b0;
      chk("t6_fetch_addr_c11", bus.mem_addr, 16'h0080);
      chk("t6_fetch_en_c11", {15'd0, bus.mem_en}, 16'd1);
      repeat (4) cycle();
      chk("t6_i_valid_c15", {15'd0, bus.i_valid}, 16'd1);
      cycle();
      bus.i_req = 1'b0;
      cycle();

      // Random protocol-legal traffic
      i_hold = 1'b0; d_hold = 1'b0;
      repeat (2000) begin
         rand_drive();
         cycle();
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.i_cancel = 1'b0;
      repeat (12) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one multi-cycle, single-ported memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. Fixed data-over-instruction priority; each access holds the memory for a fixed number of cycles. Returns read data with a one-cycle valid pulse and exposes per-port stall signals that freeze the PC and pipeline registers. Sits between the pipeline control and the unified memory model.

## Interface
- LATENCY, 4: cycles the memory inputs are held per access (≥1)
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_valid or cancel
- i_addr  in  16  fetch address, stable while i_req
- i_cancel  in  1  branch redirect: discard in-flight fetch result
- i_data  out  16  fetched instruction, registered
- i_valid  out  1  one-cycle pulse, i_data valid
- i_stall  out  1  i_req & ~i_valid (combinational)
- d_req  in  1  data request, level, held until d_valid
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  16  data address
- d_wdata  in  16  store data
- d_rdata  out  16  load data, registered
- d_valid  out  1  one-cycle pulse, access complete
- d_stall  out  1  d_req & ~d_valid (combinational)
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid in last busy cycle
- busy  out  1  access in progress

## Operation
- States: IDLE, BUSY_I, BUSY_D. Down-counter cnt, width $clog2(LATENCY+1).
- IDLE: at a clock edge with d_req=1 → latch d_wr/d_addr/d_wdata, go BUSY_D. Else i_req=1 → latch i_addr, go BUSY_I. cnt ← LATENCY-1.
- Eligibility exclusion: a port's req is ignored in the cycle its own valid is high; the other port is still eligible. A held req is re-sampled the next cycle.
- BUSY_x: mem_en=1, mem_addr/mem_wdata driven from latched registers (stable for the whole access), mem_wr = latched d_wr in BUSY_D, 0 in BUSY_I. busy=1. cnt decrements each cycle.
- On the edge with cnt==0: capture mem_rdata into i_data (BUSY_I) or d_rdata (BUSY_D, loads only; stores leave d_rdata unchanged). Return to IDLE. Pulse the matching valid the following cycle.
- i_cancel: sampled high on any edge while in BUSY_I, or at the edge where BUSY_I is entered, sets a drop flag. The access runs to completion (memory cannot abort). i_data is not updated, and no i_valid is produced. The flag clears on return to IDLE. i_cancel has no effect in BUSY_D or IDLE.
- Starvation: fetch waits behind back-to-back data accesses. This is acceptable; the data port never issues back-to-back without pipeline advance.
- Outputs when IDLE: mem_en=0, mem_wr=0, mem_addr/mem_wdata hold the last latched values.

## Timing
- Request sampled at the end of cycle 0 → mem_en high cycles 1..LATENCY → valid in cycle LATENCY+1. Throughput is one access per LATENCY+1 cycles.
- A competing request pending during an access is granted at the edge ending the valid cycle. Its mem_en starts in cycle LATENCY+2.
- Reset (asynchronous, any time): state IDLE, cnt 0, drop flag 0. mem_en/mem_wr/busy/i_valid/d_valid 0. i_data/d_rdata/mem_addr/mem_wdata 0x0000.
- Reset mid-access aborts the access: no valid pulse, and mem_en drops immediately. After rst deasserts, the first edge with a request starts a normal access.
- LATENCY=1: a single busy cycle, valid in cycle 2.

## Test plan
- Single fetch, LATENCY=4, i_addr=0x0010, memory returns 0xA5A5 → mem_en=1 cycles 1–4, mem_wr=0, i_valid cycle 5 with i_data=0xA5A5, i_stall=1 cycles 0–4.
- Simultaneous requests cycle 0: i_req (0x0020), d_req load 0x0200 → 0x00FF. Expected: D granted first, d_valid cycle 5 with d_rdata=0x00FF. Fetch mem_en cycles 6–9, i_valid cycle 10.
- Store: d_wr=1, d_addr=0x0300, d_wdata=0x1234 → mem_wr=1 and mem_wdata=0x1234 cycles 1–4, d_valid cycle 5, d_rdata unchanged.
- Cancel: fetch starts cycle 0, i_cancel pulse cycle 2 → mem_en still cycles 1–4, no i_valid, i_data unchanged. A d_req raised in cycle 3 gets mem_en cycles 6–9.
- Reset mid-access: rst pulses in cycle 2 of a load → mem_en=0 and busy=0 immediately, no d_valid. After release, the held d_req completes with a full LATENCY+1 timing.
- Valid-cycle exclusion: i_req held high through i_valid (cycle 5) while d_req rises cycle 5 → D granted at end of cycle 5. The next fetch is issued only after d_valid.
